// File: rtl/alu_issue_control_32.sv
// Purpose : initiator-side controller for alu_control_32. Accepts one MIPS
//           instruction per valid/ready handshake, decodes the main controls
//           and ALUop, runs the start/finish handshake, and returns a
//           registered control bundle with error flags.
// Ports   : instr_valid/instr/instr_ready  - instruction input handshake
//           ac_*                           - alu_control_32 start/finish side
//           ctrl_valid/ctrl_ready + bundle - control bundle to the sequencer
// Latency : finish during ISSUE gives ctrl_valid 2 cycles after the cycle
//           instr is offered. Each WAIT cycle adds 1.
module alu_issue_control_32 #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [31:0] instr,
  output logic       instr_ready,
  output logic       ac_start,
  output logic [5:0] ac_func,
  output logic [1:0] ac_alu_op,
  input  logic [3:0] ac_alu_control,
  input  logic       ac_err_func,
  input  logic       ac_err_alu_op,
  input  logic       ac_finish,
  output logic       ctrl_valid,
  input  logic       ctrl_ready,
  output logic       reg_dst,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic [3:0] alu_ctrl,
  output logic       err_illegal_opcode,
  output logic       err_illegal_func,
  output logic       err_illegal_alu_op,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       lat_ctrl;   // decoded bits held for the transaction
  logic [6:0]       out_ctrl;   // bundle copy, zero unless a clean completion

  // Opcode decode; bit order {reg_dst, alu_src, mem_to_reg, reg_write,
  // mem_read, mem_write, branch}.
  logic [6:0] dec_ctrl;
  logic [1:0] dec_op;
  logic       dec_legal;

  always_comb begin
    dec_ctrl  = 7'b0;
    dec_op    = 2'b00;
    dec_legal = 1'b1;
    case (instr[31:26])
      6'b000000: begin dec_ctrl = 7'b1001000; dec_op = 2'b10; end
      6'b100011: begin dec_ctrl = 7'b0111100; dec_op = 2'b00; end
      6'b101011: begin dec_ctrl = 7'b0100010; dec_op = 2'b00; end
      6'b000100: begin dec_ctrl = 7'b0000001; dec_op = 2'b01; end
      6'b001000: begin dec_ctrl = 7'b0101000; dec_op = 2'b00; end
      default:   dec_legal = 1'b0;
    endcase
  end

  assign {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = out_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      cnt                <= '0;
      lat_ctrl           <= '0;
      out_ctrl           <= '0;
      instr_ready        <= 1'b1;
      ac_start           <= 1'b0;
      ac_func            <= '0;
      ac_alu_op          <= '0;
      ctrl_valid         <= 1'b0;
      alu_ctrl           <= '0;
      err_illegal_opcode <= 1'b0;
      err_illegal_func   <= 1'b0;
      err_illegal_alu_op <= 1'b0;
      err_timeout        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            lat_ctrl    <= dec_ctrl;
            ac_func     <= instr[5:0];
            ac_alu_op   <= dec_op;
            instr_ready <= 1'b0;
            if (dec_legal) begin
              state    <= ISSUE;
              ac_start <= 1'b1;
            end else begin
              // Illegal opcode bypasses alu_control_32 entirely.
              state              <= RESP;
              ctrl_valid         <= 1'b1;
              err_illegal_opcode <= 1'b1;
            end
          end
        end
        ISSUE: begin
          ac_start <= 1'b0;
          cnt      <= '0;
          state    <= WAIT;   // overridden below on zero-wait finish
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            // Overridden below if finish arrives in this same cycle.
            state       <= RESP;
            ctrl_valid  <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (ctrl_ready) begin
            state              <= IDLE;
            instr_ready        <= 1'b1;
            ctrl_valid         <= 1'b0;
            out_ctrl           <= '0;
            alu_ctrl           <= '0;
            err_illegal_opcode <= 1'b0;
            err_illegal_func   <= 1'b0;
            err_illegal_alu_op <= 1'b0;
            err_timeout        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Capture on finish; placed last so it wins over the timeout path.
      if (ac_finish && (state == ISSUE || state == WAIT)) begin
        state              <= RESP;
        ctrl_valid         <= 1'b1;
        err_timeout        <= 1'b0;
        alu_ctrl           <= ac_alu_control;
        err_illegal_func   <= ac_err_func;
        err_illegal_alu_op <= ac_err_alu_op;
        // A func/ALUop error turns the instruction into a no-op.
        out_ctrl           <= (ac_err_func || ac_err_alu_op) ? 7'b0 : lat_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_control_32.sv
module tb_alu_issue_control_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        ac_start;
  logic [5:0]  ac_func;
  logic [1:0]  ac_alu_op;
  logic [3:0]  ac_alu_control;
  logic        ac_err_func;
  logic        ac_err_alu_op;
  logic        ac_finish;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [3:0]  alu_ctrl;
  logic        err_illegal_opcode, err_illegal_func, err_illegal_alu_op, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_control_32 #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ac_start(ac_start), .ac_func(ac_func), .ac_alu_op(ac_alu_op),
    .ac_alu_control(ac_alu_control), .ac_err_func(ac_err_func),
    .ac_err_alu_op(ac_err_alu_op), .ac_finish(ac_finish),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .alu_ctrl(alu_ctrl),
    .err_illegal_opcode(err_illegal_opcode), .err_illegal_func(err_illegal_func),
    .err_illegal_alu_op(err_illegal_alu_op), .err_timeout(err_timeout)
  );

  // Observed bundle: {valid, 7 control bits, alu_ctrl, 4 error flags}.
  function automatic logic [15:0] bundle();
    return {ctrl_valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
            mem_write, branch, alu_ctrl, err_illegal_opcode, err_illegal_func,
            err_illegal_alu_op, err_timeout};
  endfunction

  function automatic logic [15:0] mk(input logic v, input logic [6:0] c,
                                     input logic [3:0] a, input logic [3:0] e);
    return {v, c, a, e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_bundle();
    ctrl_ready = 1'b1;
    step();
    ctrl_ready = 1'b0;
    chk("back_to_idle_ready", {31'b0, instr_ready}, 32'd1);
    chk("back_to_idle_valid", {31'b0, ctrl_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ac_alu_control = '0;
    ac_err_func = 1'b0; ac_err_alu_op = 1'b0; ac_finish = 1'b0; ctrl_ready = 1'b0;
    #12;
    chk("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_bundle", {16'b0, bundle()}, 32'd0);
    chk("rst_ac_outs", {23'b0, ac_start, ac_func, ac_alu_op}, 32'd0);
    rst_n = 1'b1;
    step();

    // finish while IDLE must be ignored
    ac_finish = 1'b1; ac_alu_control = 4'hA;
    step();
    ac_finish = 1'b0;
    chk("idle_finish_ignored", {16'b0, bundle()}, 32'd0);

    // R-type add, finish after 2 WAIT cycles
    instr = 32'h00221820; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("rtype_start", {31'b0, ac_start}, 32'd1);
    chk("rtype_func", {26'b0, ac_func}, 32'h20);
    chk("rtype_alu_op", {30'b0, ac_alu_op}, 32'd2);
    chk("rtype_busy", {31'b0, instr_ready}, 32'd0);
    step();
    chk("rtype_start_pulse", {31'b0, ac_start}, 32'd0);
    step();
    chk("rtype_func_held", {24'b0, ac_func, ac_alu_op}, {24'b0, 6'h20, 2'd2});
    ac_finish = 1'b1; ac_alu_control = 4'b0010;
    step();
    ac_finish = 1'b0;
    chk("rtype_bundle", {16'b0, bundle()}, {16'b0, mk(1'b1, 7'b1001000, 4'b0010, 4'b0000)});
    release_bundle();

    // lw, finish in ISSUE: ctrl_valid two cycles after instr offered
    instr = 32'h8C410004; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("lw_alu_op", {29'b0, ac_start, ac_alu_op}, {29'b0, 1'b1, 2'd0});
    chk("lw_not_yet_valid", {31'b0, ctrl_valid}, 32'd0);
    ac_finish = 1'b1; ac_alu_control = 4'b0010;
    step();
    ac_finish = 1'b0;
    chk("lw_bundle", {16'b0, bundle()}, {16'b0, mk(1'b1, 7'b0111100, 4'b0010, 4'b0000)});
    release_bundle();

    // beq with a 5-cycle consumer stall
    instr = 32'h10220003; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("beq_alu_op", {30'b0, ac_alu_op}, 32'd1);
    ac_finish = 1'b1; ac_alu_control = 4'b0110;
    step();
    ac_finish = 1'b0; ac_alu_control = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("beq_stall_bundle", {16'b0, bundle()}, {16'b0, mk(1'b1, 7'b0000001, 4'b0110, 4'b0000)});
      chk("beq_stall_ready", {31'b0, instr_ready}, 32'd0);
      step();
    end
    release_bundle();

    // R-type with illegal func reported by alu_control_32
    instr = 32'h0000003A; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("badfunc_func", {26'b0, ac_func}, 32'h3A);
    ac_finish = 1'b1; ac_err_func = 1'b1; ac_alu_control = 4'hF;
    step();
    ac_finish = 1'b0; ac_err_func = 1'b0;
    chk("badfunc_bundle", {16'b0, bundle()}, {16'b0, mk(1'b1, 7'b0, 4'hF, 4'b0100)});
    release_bundle();

    // illegal opcode: straight to response, no start
    instr = 32'hFC000000; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("badop_no_start", {31'b0, ac_start}, 32'd0);
    chk("badop_bundle", {16'b0, bundle()}, {16'b0, mk(1'b1, 7'b0, 4'h0, 4'b1000)});
    release_bundle();
    chk("badop_no_start_after", {31'b0, ac_start}, 32'd0);

    // timeout: 16 WAIT cycles with no finish
    instr = 32'h00221820; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("to_start", {31'b0, ac_start}, 32'd1);
    for (int i = 0; i < 16; i++) step();
    chk("to_not_early", {31'b0, ctrl_valid}, 32'd0);
    step();
    chk("to_bundle", {16'b0, bundle()}, {16'b0, mk(1'b1, 7'b0, 4'h0, 4'b0001)});
    release_bundle();

    // next instruction: finish on the last WAIT cycle beats the timeout
    instr = 32'h00221820; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("edge_still_waiting", {31'b0, ctrl_valid}, 32'd0);
    ac_finish = 1'b1; ac_alu_control = 4'b0010;
    step();
    ac_finish = 1'b0;
    chk("edge_finish_wins", {16'b0, bundle()}, {16'b0, mk(1'b1, 7'b1001000, 4'b0010, 4'b0000)});
    release_bundle();

    // asynchronous reset during WAIT
    instr = 32'h00221820; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, instr_ready}, 32'd1);
    chk("midrst_bundle", {16'b0, bundle()}, 32'd0);
    chk("midrst_ac_outs", {23'b0, ac_start, ac_func, ac_alu_op}, 32'd0);
    step();
    chk("midrst_held_bundle", {16'b0, bundle()}, 32'd0);
    rst_n = 1'b1;
    step();

    // sw after reset
    instr = 32'hAC410008; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("sw_alu_op", {29'b0, ac_start, ac_alu_op}, {29'b0, 1'b1, 2'd0});
    ac_finish = 1'b1; ac_alu_control = 4'b0010;
    step();
    ac_finish = 1'b0;
    chk("sw_bundle", {16'b0, bundle()}, {16'b0, mk(1'b1, 7'b0100010, 4'b0010, 4'b0000)});
    release_bundle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_control_32.md
Name: alu_issue_control_32

Overview:
- Initiator-side controller for `alu_control_32`: the block that produces `func`/`alu_op`, pulses `start` and consumes `finish`.
- Accepts one 32-bit MIPS instruction per valid/ready handshake and decodes the opcode into main datapath controls and a 2-bit ALUop.
- Drives the `alu_control_32` start/finish handshake, then returns a registered control bundle, including the 4-bit ALU control, with error flags to the datapath sequencer.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in WAIT without finish before err_timeout (1..255)
CNT_W, 8, width of timeout counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered
instr  input  32  instruction word; opcode = [31:26], func = [5:0]
instr_ready  output  1  high only in IDLE
ac_start  output  1  one-cycle start pulse to alu_control_32
ac_func  output  6  func code to alu_control_32
ac_alu_op  output  2  ALUop to alu_control_32
ac_alu_control  input  4  ALU control result
ac_err_func  input  1  illegal func flag from alu_control_32
ac_err_alu_op  input  1  illegal ALUop flag from alu_control_32
ac_finish  input  1  alu_control_32 done
ctrl_valid  output  1  control bundle valid
ctrl_ready  input  1  consumer accepts bundle
reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  output  1 each  main control bits
alu_ctrl  output  4  captured ac_alu_control
err_illegal_opcode  output  1  opcode not supported
err_illegal_func  output  1  captured ac_err_func
err_illegal_alu_op  output  1  captured ac_err_alu_op
err_timeout  output  1  no finish within TIMEOUT_CYCLES

Behaviour:
- Reset (`rst_n` low, async): state=IDLE.
  - All outputs 0 except `instr_ready`=1.
  - `ac_func`=0, `ac_alu_op`=0, counter=0.
  - Reset mid-transaction aborts it: no `ctrl_valid` is produced and `ac_start` drops immediately.
- Opcode decode (bits reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch ; alu_op):
  - R-type 000000 -> 1,0,0,1,0,0,0 ; 10
  - lw 100011 -> 0,1,1,1,1,0,0 ; 00
  - sw 101011 -> 0,1,0,0,0,1,0 ; 00
  - beq 000100 -> 0,0,0,0,0,0,1 ; 01
  - addi 001000 -> 0,1,0,1,0,0,0 ; 00
  - Any other opcode is illegal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`: latch opcode, `instr[5:0]`, the decoded bits and the ALUop.
  - Legal opcode -> ISSUE.
  - Illegal opcode -> RESP with `err_illegal_opcode`=1, all control bits 0, `alu_ctrl`=0; `ac_start` is never asserted.
- ISSUE (exactly 1 cycle):
  - `ac_start`=1; `ac_func`/`ac_alu_op` driven from the latch.
  - Both are held stable from ISSUE until leaving WAIT.
  - `ac_func` is forwarded unchanged for all opcodes; `alu_control_32` ignores it when ALUop≠10.
  - If `ac_finish`=1 in this cycle, capture and go to RESP (zero-wait completion); else -> WAIT with counter=0.
- WAIT:
  - `ac_start`=0; counter increments each cycle.
  - On `ac_finish`=1: capture `ac_alu_control`, `ac_err_func`, `ac_err_alu_op` into `alu_ctrl`/err regs -> RESP.
  - If counter reaches TIMEOUT_CYCLES-1 without finish -> RESP with `err_timeout`=1, `alu_ctrl`=0, control bits forced 0.
  - Finish on the same cycle as timeout expiry: finish wins, `err_timeout`=0.
- RESP:
  - `ctrl_valid`=1; the bundle is held stable until `ctrl_ready`=1, then -> IDLE, clearing `ctrl_valid` and all err flags.
  - If `err_illegal_func` or `err_illegal_alu_op` is captured, all control bits are forced 0 (the instruction becomes a no-op); `alu_ctrl` still reports the captured value.
- `ac_finish` outside ISSUE/WAIT is ignored.
- Latency: legal instruction with finish in ISSUE -> `ctrl_valid` 2 cycles after accept edge; each WAIT cycle adds 1.
- Throughput: at most one instruction per 3 cycles.
- `instr_ready` low in all states but IDLE, so there is no simultaneous accept/response.

Test Plan:
- R-type add, instr=0x00221820 (func 100000); model returns finish after 2 cycles with ac_alu_control=0010 -> ac_start one pulse, ac_alu_op=10, ac_func=100000; bundle reg_dst=1, reg_write=1, alu_ctrl=0010, no errors.
- lw 0x8C410004 with finish same cycle as start -> ac_alu_op=00; ctrl_valid 2 cycles after accept; alu_src=mem_read=mem_to_reg=reg_write=1, alu_ctrl=0010.
- beq 0x10220003; ctrl_ready held 0 for 5 cycles -> ac_alu_op=01, branch=1, alu_ctrl=0110; bundle stable and instr_ready=0 throughout the stall.
- R-type func 111010; model returns ac_err_func=1 -> err_illegal_func=1, all control bits 0; opcode 111111 -> err_illegal_opcode=1 and ac_start never pulses.
- TIMEOUT_CYCLES=16, model never asserts finish -> err_timeout=1 exactly 16 cycles after ISSUE; the next instruction completes normally afterwards.
- rst_n low during WAIT -> outputs return to reset values immediately; a following sw 0xAC410008 produces ac_alu_op=00, mem_write=1.
